// File: rtl/bitstream_pkg.sv
// Shared types, LFSR tap table and seed helper for the stochastic engine.
package bitstream_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} eng_state_t;

   // Maximal-length Fibonacci tap masks, bit k set means tap at stage k+1
   localparam logic [15:0] LFSR_TAPS [4:16] = '{
      16'h000C, 16'h0014, 16'h0030, 16'h0060, 16'h00B8,
      16'h0110, 16'h0240, 16'h0500, 16'h0829, 16'h100D,
      16'h2015, 16'h6000, 16'hD008
   };

   function automatic logic [15:0] lfsr_seed(input int width, input int ch);
      logic [15:0] ones;
      ones = 16'((32'd1 << width) - 1);
      return ones - 16'(2 * ch);
   endfunction

endpackage

// File: rtl/bitstream_sng.sv
// Stochastic number generator: LFSR plus unsigned comparator.
module bitstream_sng
   import bitstream_pkg::*;
#(
   parameter int                DATA_W = 8,
   parameter logic [DATA_W-1:0] SEED   = '1
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              load,
   input  logic              step,
   input  logic [DATA_W-1:0] operand,
   output logic              bit_out
);

   localparam logic [DATA_W-1:0] TAPS = DATA_W'(LFSR_TAPS[DATA_W]);

   logic [DATA_W-1:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (load)
         lfsr_d = SEED;
      else if (step)
         lfsr_d = {lfsr_q[DATA_W-2:0], ^(lfsr_q & TAPS)};
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         lfsr_q <= SEED;
      else
         lfsr_q <= lfsr_d;
   end

   assign bit_out = operand > lfsr_q;

endmodule

// File: rtl/stochastic_eval_engine.sv
// Stochastic evaluation engine: operand latch, SNG bank, combiner,
// ones counter and start/busy/done sequencing.
module stochastic_eval_engine
   import bitstream_pkg::*;
#(
   parameter int N_IN       = 2,
   parameter int DATA_W     = 8,
   parameter int STREAM_LEN = 255,
   parameter int MODE       = 0
) (
   input  logic                             clk,
   input  logic                             n_rst,
   input  logic                             start,
   input  logic [N_IN*DATA_W-1:0]           data_in,
   output logic                             busy,
   output logic                             done,
   output logic                             result_valid,
   output logic [$clog2(STREAM_LEN+1)-1:0]  result,
   output logic                             stream_out
);

   localparam int RES_W = $clog2(STREAM_LEN + 1);
   localparam int RR_W  = (N_IN > 1) ? $clog2(N_IN) : 1;

   eng_state_t               state_q, state_d;
   logic [N_IN*DATA_W-1:0]   ops_q, ops_d;
   logic [RES_W-1:0]         cnt_q, cnt_d;
   logic [RES_W-1:0]         cyc_q, cyc_d;
   logic [RES_W-1:0]         result_q, result_d;
   logic [RR_W-1:0]          rr_q, rr_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic                     valid_q, valid_d;
   logic [N_IN-1:0]          bits;
   logic                     comb_bit;

   for (genvar g = 0; g < N_IN; g++) begin : g_sng
      bitstream_sng #(
         .DATA_W (DATA_W),
         .SEED   (DATA_W'(lfsr_seed(DATA_W, g)))
      ) u_sng (
         .clk     (clk),
         .n_rst   (n_rst),
         .load    (state_q == LOAD),
         .step    (state_q == RUN),
         .operand (ops_q[g*DATA_W +: DATA_W]),
         .bit_out (bits[g])
      );
   end

   always_comb begin
      comb_bit = 1'b0;
      if (MODE == 0)
         comb_bit = &bits;
      else
         comb_bit = bits[rr_q];
   end

   assign stream_out = (state_q == RUN) && comb_bit;

   always_comb begin
      state_d  = state_q;
      ops_d    = ops_q;
      cnt_d    = cnt_q;
      cyc_d    = cyc_q;
      rr_d     = rr_q;
      result_d = result_q;
      busy_d   = busy_q;
      valid_d  = valid_q;
      done_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD;
               ops_d   = data_in;
               busy_d  = 1'b1;
               valid_d = 1'b0;
            end
         end
         LOAD: begin
            state_d = RUN;
            cnt_d   = '0;
            cyc_d   = '0;
            rr_d    = '0;
         end
         RUN: begin
            cnt_d = cnt_q + RES_W'(comb_bit);
            cyc_d = cyc_q + 1'b1;
            rr_d  = (rr_q == RR_W'(N_IN - 1)) ? '0 : rr_q + 1'b1;
            // Publish on the last RUN edge so result is valid with done
            if (cyc_q == RES_W'(STREAM_LEN - 1)) begin
               state_d  = DONE;
               result_d = cnt_d;
               done_d   = 1'b1;
               valid_d  = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q  <= IDLE;
         ops_q    <= '0;
         cnt_q    <= '0;
         cyc_q    <= '0;
         rr_q     <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         ops_q    <= ops_d;
         cnt_q    <= cnt_d;
         cyc_q    <= cyc_d;
         rr_q     <= rr_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         valid_q  <= valid_d;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign result_valid = valid_q;
   assign result       = result_q;

endmodule

// File: tb/tb_stochastic_eval_engine.sv
// Bench for stochastic_eval_engine: three configurations checked
// against a bitstream-level reference model.
module tb_stochastic_eval_engine;
   import bitstream_pkg::*;

   localparam int LEN = 255;
   localparam int LAT = LEN + 2;

   logic       clk = 1'b0;
   logic       n_rst;
   logic       st   [3];
   logic [15:0] din [3];
   logic       bsy  [3];
   logic       dn   [3];
   logic       rv   [3];
   logic       so   [3];
   logic [7:0] res  [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // d0: one channel multiply, d1: two channel multiply, d2: two channel add
   stochastic_eval_engine #(.N_IN(1), .DATA_W(8), .STREAM_LEN(LEN), .MODE(0)) u_d0 (
      .clk(clk), .n_rst(n_rst), .start(st[0]), .data_in(din[0][7:0]),
      .busy(bsy[0]), .done(dn[0]), .result_valid(rv[0]), .result(res[0]),
      .stream_out(so[0]));
   stochastic_eval_engine #(.N_IN(2), .DATA_W(8), .STREAM_LEN(LEN), .MODE(0)) u_d1 (
      .clk(clk), .n_rst(n_rst), .start(st[1]), .data_in(din[1]),
      .busy(bsy[1]), .done(dn[1]), .result_valid(rv[1]), .result(res[1]),
      .stream_out(so[1]));
   stochastic_eval_engine #(.N_IN(2), .DATA_W(8), .STREAM_LEN(LEN), .MODE(1)) u_d2 (
      .clk(clk), .n_rst(n_rst), .start(st[2]), .data_in(din[2]),
      .busy(bsy[2]), .done(dn[2]), .result_valid(rv[2]), .result(res[2]),
      .stream_out(so[2]));

   typedef struct {
      int d;
      int op0;
      int op1;
      int exp;
      int tol;
   } vec_t;

   function automatic int lfsr_next(int s);
      int fb;
      fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
      return ((s << 1) | fb) & 255;
   endfunction

   function automatic int model(int d, int op0, int op1);
      int s0, s1, cnt, b0, b1, b;
      s0  = int'(lfsr_seed(8, 0));
      s1  = int'(lfsr_seed(8, 1));
      cnt = 0;
      for (int k = 0; k < LEN; k++) begin
         b0 = (op0 > s0) ? 1 : 0;
         b1 = (op1 > s1) ? 1 : 0;
         if (d == 0)      b = b0;
         else if (d == 1) b = b0 & b1;
         else             b = (k % 2 == 0) ? b0 : b1;
         cnt += b;
         s0 = lfsr_next(s0);
         s1 = lfsr_next(s1);
      end
      return cnt;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic chk_tol(input string name, input int act, input int exp,
                          input int tol);
      int diff;
      checks++;
      diff = (act > exp) ? act - exp : exp - act;
      if (diff > tol) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d+/-%0d", name, act, exp, tol);
      end
   endtask

   task automatic run(input int d, input int op0, input int op1,
                      output int r, output int lat, output int ones);
      int k;
      din[d] = 16'((op1 << 8) | op0);
      @(negedge clk);
      st[d] = 1'b1;
      k     = 0;
      ones  = 0;
      do begin
         @(negedge clk);
         k++;
         st[d] = 1'b0;
         if (so[d]) ones++;
      end while (!dn[d] && k < 400);
      lat = k;
      r   = int'(res[d]);
      if (k >= 400) chk("timeout", 0, 1);
      chk("valid_at_done", int'(rv[d]), 1);
   endtask

   vec_t vt [7];

   initial begin
      int r, lat, ones, k, nd, r1, r2, kd1, kd2, a0, a1, b0, b1;

      vt[0] = '{0, 255, 0, 254, 0};
      vt[1] = '{0, 0,   0, 0,   0};
      vt[2] = '{0, 128, 0, 127, 0};
      vt[3] = '{1, 128, 128, 64, 12};
      vt[4] = '{1, 255, 0,  0,   0};
      vt[5] = '{2, 255, 0,  127, 1};
      vt[6] = '{2, 0,   0,  0,   0};

      for (int i = 0; i < 3; i++) begin
         st[i]  = 1'b1;
         din[i] = 16'hFFFF;
      end
      n_rst = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("rst_busy",   int'(bsy[i]), 0);
         chk("rst_done",   int'(dn[i]),  0);
         chk("rst_result", int'(res[i]), 0);
         chk("rst_stream", int'(so[i]),  0);
         chk("rst_valid",  int'(rv[i]),  0);
      end
      for (int i = 0; i < 3; i++) st[i] = 1'b0;
      n_rst = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         run(vt[i].d, vt[i].op0, vt[i].op1, r, lat, ones);
         chk_tol($sformatf("vec%0d_result", i), r, vt[i].exp, vt[i].tol);
         chk($sformatf("vec%0d_model", i), r, model(vt[i].d, vt[i].op0, vt[i].op1));
         chk($sformatf("vec%0d_latency", i), lat, LAT);
         chk($sformatf("vec%0d_stream", i), ones, r);
         @(negedge clk);
         chk($sformatf("vec%0d_hold", i), int'(res[vt[i].d]), r);
      end

      // start during RUN and in the DONE cycle is ignored; next IDLE accepted
      a0 = 200; a1 = 150; b0 = 90; b1 = 240;
      din[1] = 16'((a1 << 8) | a0);
      @(negedge clk);
      st[1] = 1'b1;
      k = 0; nd = 0; kd1 = -1; kd2 = -1; r1 = -1; r2 = -1;
      while (k < 560) begin
         @(negedge clk);
         k++;
         st[1] = 1'b0;
         if (k == 50) begin
            st[1]  = 1'b1;
            din[1] = 16'((b1 << 8) | b0);
         end
         if (dn[1]) begin
            nd++;
            if (kd1 < 0) begin
               kd1 = k; r1 = int'(res[1]);
            end else begin
               kd2 = k; r2 = int'(res[1]);
            end
         end
         if (k == kd1) st[1] = 1'b1;
         if (k == LAT + 1) begin
            chk("b2b_idle_busy", int'(bsy[1]), 0);
            st[1] = 1'b1;
         end
         if (k == LAT + 2) begin
            chk("b2b_accept_busy", int'(bsy[1]), 1);
            chk("b2b_valid_clear", int'(rv[1]), 0);
            chk("b2b_hold_result", int'(res[1]), r1);
         end
      end
      chk("b2b_first_done", kd1, LAT);
      chk("b2b_first_result", r1, model(1, a0, a1));
      chk("b2b_second_done", kd2, 2 * LAT + 1);
      chk("b2b_second_result", r2, model(1, b0, b1));
      chk("b2b_done_count", nd, 2);

      // reset in the middle of a run
      din[0] = 16'd255;
      @(negedge clk);
      st[0] = 1'b1;
      nd = 0;
      for (int j = 1; j < 400; j++) begin
         @(negedge clk);
         st[0] = 1'b0;
         if (j == 102) n_rst = 1'b0;
         if (j == 103) begin
            chk("mid_rst_busy",   int'(bsy[0]), 0);
            chk("mid_rst_done",   int'(dn[0]),  0);
            chk("mid_rst_valid",  int'(rv[0]),  0);
            chk("mid_rst_result", int'(res[0]), 0);
            chk("mid_rst_stream", int'(so[0]),  0);
         end
         if (j == 104) n_rst = 1'b1;
         if (dn[0]) nd++;
      end
      chk("mid_rst_no_done", nd, 0);
      run(0, 255, 0, r, lat, ones);
      chk("mid_rst_rerun", r, 254);
      chk("mid_rst_rerun_lat", lat, LAT);

      for (int i = 0; i < 20; i++) begin
         int d, o0, o1;
         d  = int'($urandom_range(0, 2));
         o0 = int'($urandom_range(0, 255));
         o1 = int'($urandom_range(0, 255));
         run(d, o0, o1, r, lat, ones);
         chk($sformatf("rnd%0d_d%0d_%0d_%0d", i, d, o0, o1), r, model(d, o0, o1));
         chk($sformatf("rnd%0d_latency", i), lat, LAT);
         chk($sformatf("rnd%0d_stream", i), ones, r);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
